sumres_seq_ctrl: RTL and testbench

//  Sequencing controller for the 4-bit add/subtract + two-digit 7-segment display path.
//  On a start request it latches both operands, orders them for subtraction, and runs a bit-serial add/sub.
//  It then converts the result to BCD (tens/units) and time-multiplexes the two digits.

---
 rtl/sumres_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sumres_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sumres_seq_ctrl.sv
// Add/sub sequencer: bit-serial add/sub, BCD conversion, 2-digit display mux.
// Ports: clk_in, rst_n, start/op/in_a/in_b in; busy/done/sign0/digit/dis0/dis1 out.
module sumres_seq_ctrl #(
  parameter int REFRESH_DIV = 100,
  parameter int CNT_W       = 7
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       busy,
  output logic       done,
  output logic       sign0,
  output logic [3:0] digit,
  output logic       dis0,
  output logic       dis1
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_BCD,
    S_DONE
  } state_t;

  state_t           state;
  logic [3:0]       x;
  logic [3:0]       y;
  logic [2:0]       sum;
  logic             opr;
  logic             neg;
  logic             cy;
  logic [2:0]       cnt;
  logic [12:0]      sh;
  logic [3:0]       tens;
  logic [3:0]       units;
  logic [CNT_W-1:0] rcnt;

  logic        yb;
  logic        s_bit;
  logic        c_nx;
  logic [4:0]  r_nx;
  logic [3:0]  tu;
  logic [3:0]  uu;
  logic [12:0] dab;
  logic        last_bcd;
  logic        wrap;
  logic        dis0_nx;
  logic [3:0]  tens_nx;
  logic [3:0]  units_nx;

  // Full-adder cell on the current LSB of the shifting operands
  always_comb begin
    yb    = y[0] ^ opr;
    s_bit = x[0] ^ yb ^ cy;
    c_nx  = (x[0] & yb) | (x[0] & cy) | (yb & cy);
    // Subtraction carry-out is only the two's-complement artefact
    r_nx  = opr ? {1'b0, s_bit, sum}
                : {c_nx, s_bit, sum};
  end

  // One shift-add-3 step: [12:9] tens, [8:5] units, [4:0] binary
  always_comb begin
    tu  = sh[12:9];
    uu  = sh[8:5];
    if (tu >= 4'd5) tu = tu + 4'd3;
    if (uu >= 4'd5) uu = uu + 4'd3;
    dab = {tu[2:0], uu, sh[4:0], 1'b0};
  end

  always_comb begin
    last_bcd = (state == S_BCD) && (cnt == 3'd4);
    wrap     = (rcnt == CNT_W'(REFRESH_DIV - 1));
    dis0_nx  = wrap ? ~dis0 : dis0;
    tens_nx  = last_bcd ? dab[12:9] : tens;
    units_nx = last_bcd ? dab[8:5] : units;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sign0 <= 1'b1;
      x     <= '0;
      y     <= '0;
      sum   <= '0;
      opr   <= 1'b0;
      neg   <= 1'b0;
      cy    <= 1'b0;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (op && (in_a < in_b)) begin
              x   <= in_b;
              y   <= in_a;
              neg <= 1'b1;
            end else begin
              x   <= in_a;
              y   <= in_b;
              neg <= 1'b0;
            end
            opr   <= op;
            cy    <= op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          sum <= {s_bit, sum[2:1]};
          cy  <= c_nx;
          x   <= {1'b0, x[3:1]};
          y   <= {1'b0, y[3:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            sh    <= {8'd0, r_nx};
            cnt   <= '0;
            state <= S_BCD;
          end
        end
        S_BCD: begin
          sh  <= dab;
          cnt <= cnt + 3'd1;
          if (last_bcd) begin
            cnt   <= '0;
            done  <= 1'b1;
            sign0 <= ~neg;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Display refresh runs regardless of the sequencer state
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= '0;
      units <= '0;
      rcnt  <= '0;
      dis0  <= 1'b0;
      dis1  <= 1'b1;
      digit <= '0;
    end else begin
      tens  <= tens_nx;
      units <= units_nx;
      rcnt  <= wrap ? '0 : rcnt + 1'b1;
      dis0  <= dis0_nx;
      dis1  <= ~dis0_nx;
      digit <= dis0_nx ? units_nx : tens_nx;
    end
  end

endmodule

// File: tb/tb_sumres_seq_ctrl.sv
// Testbench for sumres_seq_ctrl: random ops vs arithmetic reference model.
// Checks latency, display mux, start-ignore, abort and refresh period.
module tb_sumres_seq_ctrl;

  localparam int DIV = 4;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       busy;
  logic       done;
  logic       sign0;
  logic [3:0] digit;
  logic       dis0;
  logic       dis1;

  int total = 0;
  int bad   = 0;

  int exp_t = 0;
  int exp_u = 0;
  logic exp_s = 1'b1;

  always #5 clk_in = ~clk_in;

  sumres_seq_ctrl #(
    .REFRESH_DIV(DIV),
    .CNT_W(2)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .in_a(in_a),
    .in_b(in_b),
    .busy(busy),
    .done(done),
    .sign0(sign0),
    .digit(digit),
    .dis0(dis0),
    .dis1(dis1)
  );

  task automatic run_op(input logic [3:0] a,
                        input logic [3:0] b,
                        input logic o,
                        input bit poke);
    int r;
    int n;
    int want;
    bit got;
    logic ns;
    r  = o ? ((a >= b) ? a - b : b - a) : a + b;
    ns = !(o && (a < b));
    @(negedge clk_in);
    in_a = a; in_b = b; op = o; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_start got=%b want=1", busy);
    end
    if (poke) begin
      in_a = 4'($urandom_range(15));
      in_b = 4'($urandom_range(15));
      op   = 1'($urandom_range(1));
    end
    got = 0;
    n = 1;
    while (n <= 15) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      want = dis0 ? exp_u : exp_t;
      total++;
      if (digit !== 4'(want) || dis0 === dis1) begin
        bad++;
        $display("FAIL hold_display got=%0d dis0=%b dis1=%b want=%0d",
                 digit, dis0, dis1, want);
      end
      if (poke) start = 1'($urandom_range(1));
      @(negedge clk_in);
      n++;
    end
    start = 1'b0;
    total++;
    if (!got || n != 10) begin
      bad++;
      $display("FAIL latency got=%0d want=10 (seen=%0d)", n, got);
    end
    exp_t = r / 10;
    exp_u = r % 10;
    exp_s = ns;
    total++;
    if (sign0 !== exp_s || busy !== 1'b1) begin
      bad++;
      $display("FAIL sign_busy sign0=%b busy=%b want sign0=%b busy=1",
               sign0, busy, exp_s);
    end
    if (poke) start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_done done=%b busy=%b want 0 0", done, busy);
    end
    for (int j = 0; j < 2 * DIV + 1; j++) begin
      want = dis0 ? exp_u : exp_t;
      total++;
      if (digit !== 4'(want) || dis0 === dis1 || sign0 !== exp_s) begin
        bad++;
        $display("FAIL result a=%0d b=%0d op=%b digit=%0d dis0=%b sign0=%b want=%0d sign=%b",
                 a, b, o, digit, dis0, sign0, want, exp_s);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk_in);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (sign0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_sign got=%b want=1", sign0);
    end
    total++;
    if (dis1 !== 1'b1 || dis0 !== 1'b0 || digit !== 4'd0) begin
      bad++;
      $display("FAIL reset_disp dis1=%b dis0=%b digit=%0d want 1 0 0",
               dis1, dis0, digit);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    total++;
    if (dis1 !== 1'b1 || dis0 !== 1'b0 || digit !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold dis1=%b dis0=%b digit=%0d busy=%b",
               dis1, dis0, digit, busy);
    end
  endtask

  task automatic test_add;
    run_op(4'd9, 4'd8, 1'b0, 0);
  endtask

  task automatic test_sub;
    run_op(4'd3, 4'd7, 1'b1, 0);
    run_op(4'd7, 4'd3, 1'b1, 0);
  endtask

  task automatic test_bounds;
    run_op(4'd15, 4'd15, 1'b0, 0);
    run_op(4'd5, 4'd5, 1'b1, 0);
    run_op(4'd0, 4'd0, 1'b0, 0);
    run_op(4'd0, 4'd15, 1'b1, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)),
             1'($urandom_range(1)), 0);
  endtask

  task automatic test_ignore;
    for (int i = 0; i < 6; i++)
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)),
             1'($urandom_range(1)), 1);
  endtask

  task automatic test_abort;
    bit seen;
    @(negedge clk_in);
    in_a = 4'd12; in_b = 4'd9; op = 1'b0; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sign0 !== 1'b1 ||
        dis1 !== 1'b1 || dis0 !== 1'b0 || digit !== 4'd0) begin
      bad++;
      $display("FAIL abort_reset busy=%b done=%b sign0=%b dis1=%b dis0=%b digit=%0d",
               busy, done, sign0, dis1, dis0, digit);
    end
    exp_t = 0; exp_u = 0; exp_s = 1'b1;
    @(negedge clk_in);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_quiet got activity=1 want=0");
    end
    run_op(4'd6, 4'd13, 1'b1, 0);
  endtask

  task automatic test_refresh;
    logic prev;
    int run;
    bit first;
    @(negedge clk_in);
    prev = dis0;
    run = 0;
    first = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      run++;
      if (dis0 !== prev) begin
        if (!first) begin
          total++;
          if (run != DIV) begin
            bad++;
            $display("FAIL refresh_period got=%0d want=%0d", run, DIV);
          end
        end
        first = 0;
        run = 0;
        prev = dis0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_bounds;
    test_random;
    test_ignore;
    test_abort;
    test_refresh;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
